// File: rtl/dff_arb_pkg.sv
// Shared types and constants for the shared capture-register arbiter.
// Contents: FSM state enum, index-width helper, stats counter width/limit.
package dff_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  localparam int unsigned CNT_W   = 8;
  localparam logic [7:0]  CNT_MAX = 8'd255;

  // Bits needed to hold 0..n-1; never less than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dff_capture_arbiter_if.sv
// Requester/capture bus between the producer blocks and the arbiter.
// Signals: req/din (requesters -> arbiter); ack, q, q_valid, q_owner,
// busy, cap_cnt (arbiter -> consumers). master = requester side,
// slave = arbiter side.
interface dff_capture_arbiter_if
  import dff_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 1
) ();

  localparam int unsigned IDX_W = idx_w(NREQ);

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] din;
  logic [NREQ-1:0]   ack;
  logic [W-1:0]      q;
  logic              q_valid;
  logic [IDX_W-1:0]  q_owner;
  logic              busy;
  logic [CNT_W-1:0]  cap_cnt;

  modport master (
    output req, din,
    input  ack, q, q_valid, q_owner, busy, cap_cnt
  );

  modport slave (
    input  req, din,
    output ack, q, q_valid, q_owner, busy, cap_cnt
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit searching from ptr
// upward, wrapping modulo NREQ.
// Ports: req (requests), ptr (search start), any (some request set),
// idx (winning requester index).
module rr_pick
  import dff_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]           req,
  input  logic [idx_w(NREQ)-1:0]    ptr,
  output logic                      any,
  output logic [idx_w(NREQ)-1:0]    idx
);

  localparam int unsigned IDX_W = idx_w(NREQ);

  logic [NREQ-1:0] rot;
  int unsigned     sum;

  // rot[i] is the request at position ptr+i; scanning downward leaves the
  // lowest offset (closest to ptr) as the final winner.
  always_comb begin
    rot = NREQ'({req, req} >> ptr);
    any = |req;
    idx = '0;
    sum = 0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = 32'(ptr) + 32'(i);
        if (sum >= NREQ) sum = sum - NREQ;
        idx = IDX_W'(sum);
      end
    end
  end

endmodule

// File: rtl/dff_capture_arbiter.sv
// Round-robin arbiter sharing one W-bit capture register among NREQ
// requesters. A winner's data is captured, acked for one cycle and held
// with q_valid high for HOLD_CYC cycles before the next arbitration.
// Ports: clk, rst_n (async active-low), bus (slave side of
// dff_capture_arbiter_if: req, din in; ack, q, q_valid, q_owner, busy,
// cap_cnt out).
// Build option: define CAP_STATS_EN for a saturating 8-bit capture count on
// cap_cnt; otherwise cap_cnt is constant zero.
module dff_capture_arbiter
  import dff_arb_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned W        = 1,
  parameter int unsigned HOLD_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dff_capture_arbiter_if.slave  bus
);

  localparam int unsigned IDX_W = idx_w(NREQ);
  localparam int unsigned HC_W  = idx_w(HOLD_CYC);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [HC_W-1:0]  hold_q, hold_d;
  logic [W-1:0]     q_q, q_d;
  logic             q_valid_q, q_valid_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             busy_q, busy_d;

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Next-state and registered-output logic; ack defaults low so it pulses.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    owner_d   = owner_q;
    ack_d     = '0;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d   = HOLD;
          q_d       = W'(bus.din >> (32'(pick_idx) * W));
          owner_d   = pick_idx;
          ack_d     = NREQ'(1) << pick_idx;
          q_valid_d = 1'b1;
          busy_d    = 1'b1;
          hold_d    = HC_W'(HOLD_CYC - 1);
          ptr_d     = (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
        end
      end
      HOLD: begin
        if (hold_q == '0) begin
          state_d   = IDLE;
          q_valid_d = 1'b0;
          busy_d    = 1'b0;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      owner_q   <= '0;
      ack_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      owner_q   <= owner_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.ack     = ack_q;
  assign bus.q       = q_q;
  assign bus.q_valid = q_valid_q;
  assign bus.q_owner = owner_q;
  assign bus.busy    = busy_q;

`ifdef CAP_STATS_EN
  logic [CNT_W-1:0] cap_cnt_q, cap_cnt_d;

  // Saturating capture count; a capture is an IDLE cycle with a winner.
  always_comb begin
    cap_cnt_d = cap_cnt_q;
    if ((state_q == IDLE) && pick_any && (cap_cnt_q != CNT_MAX))
      cap_cnt_d = cap_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cap_cnt_q <= '0;
    else        cap_cnt_q <= cap_cnt_d;
  end

  assign bus.cap_cnt = cap_cnt_q;
`else
  assign bus.cap_cnt = '0;
`endif

endmodule

// File: tb/tb_dff_capture_arbiter.sv
// Directed self-checking bench for dff_capture_arbiter (NREQ=4, W=1,
// HOLD_CYC=2). Outputs are sampled 1 time unit after the rising edge.
module tb_dff_capture_arbiter;
  import dff_arb_pkg::*;

  localparam int unsigned NREQ     = 4;
  localparam int unsigned W        = 1;
  localparam int unsigned HOLD_CYC = 2;

`ifdef CAP_STATS_EN
  localparam int unsigned EXP_ONE = 1;
  localparam int unsigned EXP_SAT = 255;
`else
  localparam int unsigned EXP_ONE = 0;
  localparam int unsigned EXP_SAT = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dff_capture_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  dff_capture_arbiter #(.NREQ(NREQ), .W(W), .HOLD_CYC(HOLD_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Short reset pulse placed between clock edges.
  task automatic pulse_reset();
    bus.req = '0;
    rst_n   = 1'b0;
    #3;
    rst_n   = 1'b1;
  endtask

  initial begin
    int n;
    logic [3:0] exp_ack;
    int unsigned own_tab [5] = '{0, 1, 2, 3, 0};
    logic        q_tab   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    // 1. Reset with random inputs
    rst_n   = 1'b0;
    bus.req = '0;
    bus.din = '0;
    for (int i = 0; i < 3; i++) begin
      bus.req = 4'($urandom);
      bus.din = 4'($urandom);
      tick();
    end
    check("rst_q",       32'(bus.q),       32'd0);
    check("rst_q_valid", 32'(bus.q_valid), 32'd0);
    check("rst_ack",     32'(bus.ack),     32'd0);
    check("rst_busy",    32'(bus.busy),    32'd0);
    check("rst_owner",   32'(bus.q_owner), 32'd0);
    check("rst_cap_cnt", 32'(bus.cap_cnt), 32'd0);

    // 2. Single request from requester 2
    bus.req = '0;
    rst_n   = 1'b1;
    #2;
    bus.req = 4'b0100;
    bus.din = 4'b0100;
    tick();
    check("single_q",     32'(bus.q),       32'd1);
    check("single_owner", 32'(bus.q_owner), 32'd2);
    check("single_ack",   32'(bus.ack),     32'b0100);
    check("single_qv0",   32'(bus.q_valid), 32'd1);
    check("single_busy",  32'(bus.busy),    32'd1);
    check("single_cnt",   32'(bus.cap_cnt), 32'(EXP_ONE));
    bus.req = '0;
    tick();
    check("single_ack_off", 32'(bus.ack),     32'd0);
    check("single_qv1",     32'(bus.q_valid), 32'd1);
    tick();
    check("single_qv_end",  32'(bus.q_valid), 32'd0);
    check("single_idle",    32'(bus.busy),    32'd0);
    check("single_q_hold",  32'(bus.q),       32'd1);

    // 3. Fairness with all requesters held
    pulse_reset();
    bus.req = 4'b1111;
    bus.din = 4'b1010;
    for (int e = 0; e < 13; e++) begin
      tick();
      if (e % 3 == 0) begin
        exp_ack = 4'b0001 << own_tab[e / 3];
        check($sformatf("fair_ack_e%0d", e),   32'(bus.ack),     32'(exp_ack));
        check($sformatf("fair_owner_e%0d", e), 32'(bus.q_owner), own_tab[e / 3]);
        check($sformatf("fair_q_e%0d", e),     32'(bus.q),       32'(q_tab[e / 3]));
      end else begin
        check($sformatf("fair_ack_e%0d", e), 32'(bus.ack), 32'd0);
      end
      check($sformatf("fair_qv_e%0d", e), 32'(bus.q_valid), (e % 3 == 2) ? 32'd0 : 32'd1);
    end

    // 4. Asynchronous reset during HOLD of owner 2
    pulse_reset();
    bus.req = 4'b0100;
    bus.din = 4'b0100;
    tick();
    check("mid_owner_pre", 32'(bus.q_owner), 32'd2);
    bus.req = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_q",       32'(bus.q),       32'd0);
    check("mid_q_valid", 32'(bus.q_valid), 32'd0);
    check("mid_busy",    32'(bus.busy),    32'd0);
    check("mid_owner",   32'(bus.q_owner), 32'd0);
    check("mid_cap_cnt", 32'(bus.cap_cnt), 32'd0);
    rst_n = 1'b1;
    tick();
    check("mid_first_ack", 32'(bus.ack),     32'b0001);
    check("mid_first_own", 32'(bus.q_owner), 32'd0);

    // 5. Request withdrawn while requester 1 is served
    pulse_reset();
    bus.req = 4'b0010;
    bus.din = 4'b0000;
    tick();
    check("wd_ack1", 32'(bus.ack), 32'b0010);
    bus.req = 4'b1000;
    tick();
    check("wd_ack_h1", 32'(bus.ack), 32'd0);
    bus.req = 4'b0000;
    tick();
    check("wd_ack_h2", 32'(bus.ack),  32'd0);
    check("wd_busy_a", 32'(bus.busy), 32'd0);
    tick();
    check("wd_ack_idle", 32'(bus.ack),     32'd0);
    check("wd_busy_b",   32'(bus.busy),    32'd0);
    check("wd_owner",    32'(bus.q_owner), 32'd1);

    // 6. 300 back-to-back captures saturate the stats counter
    pulse_reset();
    bus.req = 4'b0001;
    bus.din = 4'b0001;
    tick();
    check("stat_first_ack", 32'(bus.ack),     32'b0001);
    check("stat_first_cnt", 32'(bus.cap_cnt), 32'(EXP_ONE));
    n = 1;
    for (int c = 0; c < 2000 && n < 300; c++) begin
      tick();
      if (bus.ack != '0) n++;
    end
    check("stat_acks",    32'(n),           32'd300);
    check("stat_cap_cnt", 32'(bus.cap_cnt), 32'(EXP_SAT));
    bus.req = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
